// File: rtl/z80_mem_arbiter_if.sv
// CPU, SPI-slave and RAM port-A signals seen by the Z80/ESP32 memory arbiter.
// slave = arbiter side, master = the surrounding system (CPU, SPI slave, RAM).
interface z80_mem_arbiter_if #(
   parameter int ADDR_BITS = 16
);
   logic                 cpu_mreq_n;
   logic                 cpu_wr_n;
   logic [ADDR_BITS-1:0] cpu_addr;
   logic [7:0]           cpu_dout;
   logic [7:0]           cpu_din;

   logic                 spi_wr;
   logic                 spi_rd;
   logic [31:0]          spi_addr;
   logic [7:0]           spi_wdata;
   logic [7:0]           spi_rdata;
   logic                 spi_rvalid;

   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [7:0]           mem_wdata;
   logic [7:0]           mem_rdata;

   modport slave (
      input  cpu_mreq_n, cpu_wr_n, cpu_addr, cpu_dout,
      input  spi_wr, spi_rd, spi_addr, spi_wdata,
      input  mem_rdata,
      output cpu_din, spi_rdata, spi_rvalid,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_mreq_n, cpu_wr_n, cpu_addr, cpu_dout,
      output spi_wr, spi_rd, spi_addr, spi_wdata,
      output mem_rdata,
      input  cpu_din, spi_rdata, spi_rvalid,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/z80_mem_arbiter.sv
// Z80 / ESP32-SPI arbiter for one sync-read RAM port: CPU clock-enable, CPU reset,
// SPI control register, one-entry SPI buffer with bounded deferral and wait-state stall.
module z80_mem_arbiter #(
   parameter int                   ADDR_BITS  = 16,
   parameter int                   DIV_BITS   = 3,
   parameter int                   PWRUP_BITS = 16,
   parameter logic [7:0]           CTRL_PAGE  = 8'hFF,
   parameter logic [7:0]           RAM_PAGE   = 8'h00,
   parameter logic [ADDR_BITS-1:0] ROM_TOP    = 'h4000,
   parameter bit                   ROM_WP     = 1'b1,
   parameter int                   DEFER_MAX  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_reset_n,
   output logic               cpu_ce,
   output logic               cpu_reset_n,
   output logic               cpu_wait_n,
   output logic [7:0]         ctrl,
   output logic               overrun,
   z80_mem_arbiter_if.slave   bus
);

   localparam int AGE_W = (DEFER_MAX > 1) ? $clog2(DEFER_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PEND,
      S_STALL,
      S_ISSUE
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_BITS-1:0]  div_cnt;
   logic [PWRUP_BITS-1:0] pwr_cnt;
   logic                 pwr_sat;
   logic [AGE_W-1:0]     age_q;
   logic                 stalled_q;

   logic                 buf_rd;
   logic [ADDR_BITS-1:0] buf_addr;
   logic [7:0]           buf_data;

   logic [1:0]           vld_pipe;
   logic [7:0]           spi_rdata_q;

   logic                 loading;
   logic [7:0]           spi_page;
   logic                 ram_op, ctrl_wr, op_rd;
   logic                 buf_busy, direct, accept, drop;
   logic                 wp_hit, cpu_wr;
   logic                 rd_issue;
   logic                 spi_addr_unused;

   assign spi_addr_unused = ^bus.spi_addr[23:ADDR_BITS];

   assign loading  = ctrl[1];
   assign spi_page = bus.spi_addr[31:24];
   assign ram_op   = (bus.spi_wr | bus.spi_rd) & (spi_page == RAM_PAGE);
   assign ctrl_wr  = bus.spi_wr & (spi_page == CTRL_PAGE);
   assign op_rd    = bus.spi_rd & ~bus.spi_wr;
   assign buf_busy = (state_q == S_PEND) | (state_q == S_STALL);
   // Loading mode bypasses the buffer only when nothing is queued ahead of the op.
   assign direct   = loading & ram_op & (state_q == S_IDLE);
   assign accept   = ram_op & ~direct & ((state_q == S_IDLE) | (state_q == S_ISSUE));
   assign drop     = ram_op & buf_busy;
   assign wp_hit   = ROM_WP & (bus.cpu_addr < ROM_TOP);
   assign cpu_wr   = ~bus.cpu_mreq_n & ~bus.cpu_wr_n;
   assign pwr_sat  = &pwr_cnt;

   assign cpu_ce         = &div_cnt;
   assign cpu_wait_n     = ~(loading | (state_q == S_STALL) | ((state_q == S_ISSUE) & stalled_q));
   assign bus.cpu_din    = bus.mem_rdata;
   assign bus.spi_rvalid = vld_pipe[1];
   assign bus.spi_rdata  = spi_rdata_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (accept) state_d = (bus.cpu_mreq_n | loading) ? S_ISSUE : S_PEND;
         S_PEND:
            if (bus.cpu_mreq_n | loading)               state_d = S_ISSUE;
            else if (age_q == AGE_W'(DEFER_MAX - 1))    state_d = S_STALL;
         S_STALL:
            state_d = S_ISSUE;
         S_ISSUE:
            if (accept) state_d = (bus.cpu_mreq_n | loading) ? S_ISSUE : S_PEND;
            else        state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_dout;
      bus.mem_we    = 1'b0;
      rd_issue      = 1'b0;
      if (state_q == S_ISSUE) begin
         bus.mem_addr  = buf_addr;
         bus.mem_wdata = buf_data;
         bus.mem_we    = ~buf_rd;
         rd_issue      = buf_rd;
      end else if (direct) begin
         bus.mem_addr  = bus.spi_addr[ADDR_BITS-1:0];
         bus.mem_wdata = bus.spi_wdata;
         bus.mem_we    = bus.spi_wr;
         rd_issue      = op_rd;
      end else if (!loading) begin
         bus.mem_we    = cpu_wr & ~wp_hit;
      end
      // A reset cycle must never disturb RAM, even with a queued op.
      if (reset) begin
         bus.mem_we = 1'b0;
         rd_issue   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         div_cnt     <= '0;
         pwr_cnt     <= '0;
         cpu_reset_n <= 1'b0;
         ctrl        <= '0;
         overrun     <= 1'b0;
         age_q       <= '0;
         stalled_q   <= 1'b0;
         buf_rd      <= 1'b0;
         buf_addr    <= '0;
         buf_data    <= '0;
         vld_pipe    <= '0;
         spi_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt     <= div_cnt + DIV_BITS'(1);
         pwr_cnt     <= pwr_sat ? pwr_cnt : pwr_cnt + PWRUP_BITS'(1);
         cpu_reset_n <= pwr_sat & btn_reset_n & ~ctrl[0];
         stalled_q   <= (state_q == S_STALL);
         if (ctrl_wr) ctrl    <= bus.spi_wdata;
         if (drop)    overrun <= 1'b1;
         if (accept) begin
            age_q    <= '0;
            buf_rd   <= op_rd;
            buf_addr <= bus.spi_addr[ADDR_BITS-1:0];
            buf_data <= bus.spi_wdata;
         end else if (state_q == S_PEND) begin
            age_q <= age_q + AGE_W'(1);
         end
         // Read data returns one clk after issue; capture it into the SPI side a clk later.
         vld_pipe <= {vld_pipe[0], rd_issue};
         if (vld_pipe[0]) spi_rdata_q <= bus.mem_rdata;
      end
   end

endmodule
